// File: rtl/chain_code_tracer_pkg.sv
// Shared constants for the chain-code tracer: FSM encodings, error codes,
// Freeman direction offsets and the clockwise search helpers.
package chain_code_tracer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_TRACE = 3'd2;
  localparam logic [2:0] ST_AREA  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_EMPTY    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  // Search starts pointing north; the numeric code for north depends on connectivity.
  localparam logic [2:0] DIR8_N = 3'd2;
  localparam logic [2:0] DIR4_N = 3'd1;

  // Row offset is negative going north, column offset positive going east.
  localparam int DR8 [8] = '{0, -1, -1, -1, 0, 1, 1, 1};
  localparam int DC8 [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  localparam int DR4 [4] = '{0, -1, 0, 1};
  localparam int DC4 [4] = '{1, 0, -1, 0};

  function automatic logic [2:0] rotate_cw(input logic [2:0] d, input logic is8);
    return is8 ? d - 3'd1 : {1'b0, d[1:0] - 2'd1};
  endfunction

  function automatic logic [2:0] restart_dir(input logic [2:0] d, input logic is8);
    if (!is8) return {1'b0, d[1:0] + 2'd1};
    return d[0] ? d + 3'd3 : d + 3'd2;
  endfunction

endpackage

// File: rtl/chain_code_tracer_row_popcount.sv
// Combinational population count of one image row, used to accumulate area.
module chain_code_tracer_row_popcount #(
  parameter int W = 64
) (
  input  logic [W-1:0]             i_row,
  output logic [$clog2(W+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(W + 1);

  // NOTE: give every always_comb output a default before any conditional update, or a latch is inferred.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) o_count = o_count + CNT_W'(i_row[i]);
  end

endmodule

// File: rtl/chain_code_tracer.sv
// Boundary tracer: scans for the first set pixel, follows the outer contour
// clockwise as Freeman codes, counts area, then streams the codes out.
module chain_code_tracer
  import chain_code_tracer_pkg::*;
#(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int MAX_CODES = 4096
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                img_we,
  input  logic [$clog2(IMG_H)-1:0]            img_row,
  input  logic [IMG_W-1:0]                    img_data,
  input  logic                                conn8,
  input  logic                                start,
  output logic                                busy,
  output logic [2:0]                          code,
  output logic                                code_valid,
  input  logic                                code_ready,
  output logic                                code_last,
  output logic                                done,
  output logic [1:0]                          error,
  output logic [$clog2(MAX_CODES+1)-1:0]      perimeter,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]    area,
  output logic [$clog2(IMG_H)-1:0]            start_x,
  output logic [$clog2(IMG_W)-1:0]            start_y
);

  localparam int RW     = $clog2(IMG_H);
  localparam int CW     = $clog2(IMG_W);
  localparam int PW     = $clog2(MAX_CODES + 1);
  localparam int MW     = $clog2(MAX_CODES);
  localparam int AREA_W = $clog2(IMG_W * IMG_H + 1);

  logic [IMG_W-1:0] r_img [IMG_H];
  logic [2:0]       r_mem [MAX_CODES];

  logic [2:0]    r_state;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_cur_r;
  logic [CW-1:0] r_cur_c;
  logic [2:0]    r_dir;
  logic [2:0]    r_first;
  logic [2:0]    r_rot;
  logic [PW-1:0] r_count;
  logic [PW-1:0] r_idx;
  logic          r_conn8;

  logic [IMG_W-1:0]         w_row;
  logic [CW-1:0]            w_col;
  logic [$clog2(IMG_W+1)-1:0] w_pop;
  int                       w_nr;
  int                       w_nc;
  logic                     w_hit;
  logic                     w_term;
  logic                     w_store;
  logic                     w_idle_or_done;
  logic [PW-1:0]            w_next_idx;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy           = !w_idle_or_done;
  assign done           = (r_state == ST_DONE);
  assign w_row          = r_img[r_row];
  assign w_next_idx     = r_idx + PW'(1);

  chain_code_tracer_row_popcount #(.W(IMG_W)) u_popcount (
    .i_row   (w_row),
    .o_count (w_pop)
  );

  always_comb begin
    w_col = '0;
    for (int i = IMG_W - 1; i >= 0; i--) if (w_row[i]) w_col = CW'(i);
  end

  // Neighbour under test; anything outside the image reads as background.
  always_comb begin
    if (r_conn8) begin
      w_nr = int'(r_cur_r) + DR8[r_dir];
      w_nc = int'(r_cur_c) + DC8[r_dir];
    end else begin
      w_nr = int'(r_cur_r) + DR4[r_dir[1:0]];
      w_nc = int'(r_cur_c) + DC4[r_dir[1:0]];
    end
    w_hit = 1'b0;
    if (w_nr >= 0 && w_nr < IMG_H && w_nc >= 0 && w_nc < IMG_W)
      w_hit = r_img[w_nr[RW-1:0]][w_nc[CW-1:0]];
  end

  assign w_term  = (r_count != '0) && (r_cur_r == start_x) && (r_cur_c == start_y) &&
                   (r_dir == r_first);
  assign w_store = (r_state == ST_TRACE) && w_hit && !w_term && (r_count < PW'(MAX_CODES));

  // NOTE: image and code storage carry no reset so they map onto plain RAM; reset only touches control state.
  always_ff @(posedge clk) begin
    if (img_we && w_idle_or_done) r_img[img_row] <= img_data;
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_count[MW-1:0]] <= r_dir;
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_cur_r    <= '0;
      r_cur_c    <= '0;
      r_dir      <= '0;
      r_first    <= '0;
      r_rot      <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_conn8    <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      code_last  <= 1'b0;
      error      <= ERR_OK;
      perimeter  <= '0;
      area       <= '0;
      start_x    <= '0;
      start_y    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_conn8   <= conn8;
            error     <= ERR_OK;
            perimeter <= '0;
            area      <= '0;
            r_row     <= '0;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (|w_row) begin
            start_x <= r_row;
            start_y <= w_col;
            r_cur_r <= r_row;
            r_cur_c <= w_col;
            r_dir   <= r_conn8 ? DIR8_N : DIR4_N;
            r_rot   <= '0;
            r_count <= '0;
            r_state <= ST_TRACE;
          end else if (r_row == RW'(IMG_H - 1)) begin
            error   <= ERR_EMPTY;
            r_state <= ST_DONE;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        ST_TRACE: begin
          if (w_hit) begin
            if (w_term) begin
              perimeter <= r_count;
              r_row     <= '0;
              r_state   <= ST_AREA;
            end else if (r_count == PW'(MAX_CODES)) begin
              error   <= ERR_OVERFLOW;
              r_state <= ST_DONE;
            end else begin
              if (r_count == '0) r_first <= r_dir;
              r_count <= r_count + PW'(1);
              r_cur_r <= w_nr[RW-1:0];
              r_cur_c <= w_nc[CW-1:0];
              r_dir   <= restart_dir(r_dir, r_conn8);
              r_rot   <= '0;
            end
          end else if (r_rot == (r_conn8 ? 3'd7 : 3'd3)) begin
            // Isolated pixel: every neighbour tested, contour is empty.
            perimeter <= '0;
            r_row     <= '0;
            r_state   <= ST_AREA;
          end else begin
            r_dir <= rotate_cw(r_dir, r_conn8);
            r_rot <= r_rot + 3'd1;
          end
        end
        ST_AREA: begin
          area <= area + AREA_W'(w_pop);
          if (r_row == RW'(IMG_H - 1)) begin
            if (perimeter != '0) begin
              code       <= r_mem[0];
              code_valid <= 1'b1;
              code_last  <= (perimeter == PW'(1));
              r_idx      <= '0;
              r_state    <= ST_EMIT;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        ST_EMIT: begin
          if (code_valid && code_ready) begin
            if (code_last) begin
              code_valid <= 1'b0;
              code_last  <= 1'b0;
              r_state    <= ST_DONE;
            end else begin
              code      <= r_mem[w_next_idx[MW-1:0]];
              r_idx     <= w_next_idx;
              code_last <= (w_next_idx == perimeter - PW'(1));
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_code_tracer.sv
// Directed bench for chain_code_tracer on a 32x16 image with an 8-entry code
// buffer, so the 3x3 block fills the buffer exactly and a 4x3 block overflows it.
module tb_chain_code_tracer;

  localparam int W = 32;
  localparam int H = 16;
  localparam int M = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          img_we = 1'b0;
  logic [3:0]    img_row = '0;
  logic [W-1:0]  img_data = '0;
  logic          conn8 = 1'b0;
  logic          start = 1'b0;
  logic          code_ready = 1'b0;
  logic          busy, code_valid, code_last, done;
  logic [2:0]    code;
  logic [1:0]    error;
  logic [3:0]    perimeter;
  logic [9:0]    area;
  logic [3:0]    start_x;
  logic [4:0]    start_y;

  int   n_chk = 0;
  int   n_err = 0;
  int   tb_cyc = 0;
  logic tb_toggle = 1'b0;
  logic tb_ready = 1'b1;
  int   got_codes[$];
  int   got_last[$];
  int   exp_q[$];
  logic prev_stall = 1'b0;
  logic [2:0] prev_code = '0;

  always #5 clk = ~clk;

  chain_code_tracer #(.IMG_W(W), .IMG_H(H), .MAX_CODES(M)) dut (
    .clk        (clk),
    .reset      (reset),
    .img_we     (img_we),
    .img_row    (img_row),
    .img_data   (img_data),
    .conn8      (conn8),
    .start      (start),
    .busy       (busy),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_last  (code_last),
    .done       (done),
    .error      (error),
    .perimeter  (perimeter),
    .area       (area),
    .start_x    (start_x),
    .start_y    (start_y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ready driver: level or toggling every two cycles.
  initial forever begin
    @(posedge clk);
    #1;
    tb_cyc++;
    code_ready = tb_toggle ? tb_cyc[1] : tb_ready;
  end

  // Stream monitor on the falling edge: records beats, checks stall stability.
  initial forever begin
    @(negedge clk);
    if (prev_stall && !reset) begin
      check("stall_valid", code_valid, 1);
      check("stall_code", code, prev_code);
    end
    if (!reset && code_valid && code_ready) begin
      got_codes.push_back(int'(code));
      got_last.push_back(int'(code_last));
    end
    prev_stall = !reset && code_valid && !code_ready;
    prev_code  = code;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [W-1:0] d);
    img_we = 1'b1; img_row = 4'(r); img_data = d;
    tick();
    img_we = 1'b0;
  endtask

  task automatic clear_image();
    for (int r = 0; r < H; r++) write_row(r, '0);
  endtask

  task automatic start_run(input logic c8);
    got_codes.delete();
    got_last.delete();
    conn8 = c8; start = 1'b1;
    tick();
    start = 1'b0; conn8 = ~c8;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic check_result(input string tag, input int perim, input int ar, input int err);
    check({tag, "_perim"}, perimeter, perim);
    check({tag, "_area"}, area, ar);
    check({tag, "_error"}, error, err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, code_valid, 0);
    check({tag, "_beats"}, got_codes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_codes.size(); i++) begin
      check($sformatf("%s_code%0d", tag, i), got_codes[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), got_last[i], (i == exp_q.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, code_valid, 0);
    check({tag, "_last"}, code_last, 0);
    check({tag, "_code"}, code, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_perim"}, perimeter, 0);
    check({tag, "_area"}, area, 0);
    check({tag, "_sx"}, start_x, 0);
    check({tag, "_sy"}, start_y, 0);
  endtask

  task automatic load_block3();
    clear_image();
    for (int r = 10; r <= 12; r++) write_row(r, 32'h0070_0000);
  endtask

  initial begin
    int n;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;

    // 3x3 block, 8-connected: exactly fills the 8-entry buffer.
    load_block3();
    start_run(1'b1);
    wait_done();
    exp_q = '{0, 0, 6, 6, 4, 4, 2, 2};
    check_result("blk8", 8, 9, 0);
    check("blk8_sx", start_x, 10);
    check("blk8_sy", start_y, 20);

    // Same image, 4-connected.
    start_run(1'b0);
    wait_done();
    exp_q = '{0, 0, 3, 3, 2, 2, 1, 1};
    check_result("blk4", 8, 9, 0);

    // 4x3 block needs 10 codes: overflow, nothing emitted.
    for (int r = 10; r <= 12; r++) write_row(r, 32'h00F0_0000);
    start_run(1'b1);
    wait_done();
    exp_q.delete();
    check_result("ovf", 0, 0, 2);

    // Single isolated pixel.
    clear_image();
    write_row(5, 32'h0000_0080);
    start_run(1'b1);
    wait_done();
    check_result("single", 0, 1, 0);
    check("single_sx", start_x, 5);
    check("single_sy", start_y, 7);

    // Empty image, then recover with one pixel (4-connected isolated case).
    clear_image();
    start_run(1'b1);
    wait_done();
    check_result("empty", 0, 0, 1);
    write_row(3, 32'h0000_0010);
    start_run(1'b0);
    wait_done();
    check_result("recover", 0, 1, 0);
    check("recover_sx", start_x, 3);
    check("recover_sy", start_y, 4);

    // Diagonal line with ready toggling.
    clear_image();
    write_row(0, 32'h1);
    write_row(1, 32'h2);
    write_row(2, 32'h4);
    tb_toggle = 1'b1;
    start_run(1'b1);
    wait_done();
    exp_q = '{7, 7, 3, 3};
    check_result("diag", 4, 3, 0);
    tb_toggle = 1'b0;

    // Reset during TRACE, then rerun.
    load_block3();
    start_run(1'b1);
    repeat (15) tick();
    check("trace_busy", busy, 1);
    reset = 1'b1;
    tick();
    check_zero("rst_trace");
    reset = 1'b0;
    start_run(1'b1);
    wait_done();
    exp_q = '{0, 0, 6, 6, 4, 4, 2, 2};
    check_result("rerun_trace", 8, 9, 0);

    // Reset during EMIT while stalled, then rerun.
    tb_ready = 1'b0;
    tick();
    tick();
    start_run(1'b1);
    n = 0;
    while (!code_valid && n < 300) begin
      tick();
      n++;
    end
    check("emit_valid", code_valid, 1);
    check("emit_code0", code, 0);
    reset = 1'b1;
    tick();
    check_zero("rst_emit");
    check("rst_emit_beats", got_codes.size(), 0);
    reset = 1'b0;
    tb_ready = 1'b1;
    tick();
    tick();
    start_run(1'b1);
    wait_done();
    check_result("rerun_emit", 8, 9, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
